// File: rtl/addr_adder_arb.sv
// Round-robin arbiter steering one requester per cycle onto a shared word-address adder,
// with a one-entry registered response. Define ADDR_ARB_OVF_EN to add the rsp_ovf carry flag.
module addr_adder_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 14,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_a,
    input  logic [NREQ*AW-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        add_a,
    output logic [AW-1:0]        add_b,
    input  logic [AW-1:0]        add_s,
    input  logic                 add_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [AW-1:0]        rsp_sum
`ifdef ADDR_ARB_OVF_EN
    ,
    output logic                 rsp_ovf
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           accept_ok;

    assign accept_ok = (state == EMPTY) || rsp_ready;
    assign rsp_valid = (state == FULL);

    // Two passes give the wrapped search order ptr..NREQ-1, then 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (rst_n && accept_ok) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!gnt_any && req[i] && (IDW'(i) >= ptr)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(i);
                    gnt[i]  = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!gnt_any && req[i] && (IDW'(i) < ptr)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(i);
                    gnt[i]  = 1'b1;
                end
            end
        end
    end

    // AND-OR steering keeps idle requesters' operands (even X) off the adder inputs.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            add_a = add_a | (req_a[i*AW +: AW] & {AW{gnt[i]}});
            add_b = add_b | (req_b[i*AW +: AW] & {AW{gnt[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            rsp_sum <= '0;
            rsp_id  <= '0;
            ptr     <= '0;
`ifdef ADDR_ARB_OVF_EN
            rsp_ovf <= 1'b0;
`endif
        end else if (gnt_any) begin
            state   <= FULL;
            rsp_sum <= add_s;
            rsp_id  <= gnt_idx;
            ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`ifdef ADDR_ARB_OVF_EN
            rsp_ovf <= add_cout;
`endif
        end else if ((state == FULL) && rsp_ready) begin
            state <= EMPTY;
        end
    end

`ifndef ADDR_ARB_OVF_EN
    logic unused_cout;
    assign unused_cout = add_cout;
`endif

endmodule

// File: tb/tb_addr_adder_arb.sv
// Self-checking bench for addr_adder_arb: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration order and the response register.
module tb_addr_adder_arb;

    localparam int NREQ = 3;
    localparam int AW   = 14;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_a;
    logic [NREQ*AW-1:0]  req_b;
    logic [NREQ-1:0]     gnt;
    logic [AW-1:0]       add_a;
    logic [AW-1:0]       add_b;
    logic [AW-1:0]       add_s;
    logic                add_cout;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [AW-1:0]       rsp_sum;
`ifdef ADDR_ARB_OVF_EN
    logic                rsp_ovf;
`endif

    logic [AW-1:0] ra [NREQ];
    logic [AW-1:0] rb [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*AW +: AW] = ra[i];
            req_b[i*AW +: AW] = rb[i];
        end
    end

    // External shared adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

    addr_adder_arb #(.NREQ(NREQ), .AW(AW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADDR_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: last served requester, and the contents of the response slot.
    bit            m_valid;
    logic [AW-1:0] m_sum;
    int            m_id;
    int            m_last;
    bit            m_ovf;
    int            last_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_last  = NREQ - 1;
        m_ovf   = 1'b0;
    endtask

    // Next served requester is the nearest one after the last served, cyclically.
    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    // Called just after a rising edge with inputs already applied; returns 1 time unit after the next edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        logic [AW-1:0]   eb;
        logic [AW:0]     s;
        #1;
        g  = exp_grant();
        eg = '0;
        ea = '0;
        eb = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea    = ra[g];
            eb    = rb[g];
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("add_a", 32'(add_a), 32'(ea));
        check("add_b", 32'(add_b), 32'(eb));
        @(posedge clk);
        if (g >= 0) begin
            s       = {1'b0, ea} + {1'b0, eb};
            m_valid = 1'b1;
            m_sum   = s[AW-1:0];
            m_ovf   = s[AW];
            m_id    = g;
            m_last  = g;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        last_g = g;
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef ADDR_ARB_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 3'b111;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        model_reset();
        last_g = -1;

        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_sum", 32'(rsp_sum), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with all requesters held
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = AW'(i);
            rb[i] = 14'h0100;
        end
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr_order", 32'(last_g), 32'(k % NREQ));
            check("rr_sum", 32'(rsp_sum), 32'h0100 + 32'(k % NREQ));
        end

        // Single request, then idle
        req   = 3'b001;
        ra[0] = 14'h0001;
        rb[0] = 14'h0001;
        step();
        check("single_sum", 32'(rsp_sum), 32'h2);
        check("single_id", 32'(rsp_id), 32'h0);
        req = 3'b000;
        step();
        check("single_drain", 32'(rsp_valid), 32'h0);

        // Backpressure: held response, no grants, then resume at requester 2
        req   = 3'b010;
        ra[1] = 14'h0008;
        rb[1] = 14'h0008;
        step();
        check("bp_load", 32'(rsp_sum), 32'h10);
        req       = 3'b101;
        rsp_ready = 1'b0;
        repeat (3) begin
            step();
            check("bp_hold_sum", 32'(rsp_sum), 32'h10);
            check("bp_hold_id", 32'(rsp_id), 32'h1);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_resume_id", 32'(rsp_id), 32'h2);

        // Address wrap
        req   = 3'b001;
        ra[0] = 14'h3FFF;
        rb[0] = 14'h0001;
        step();
        check("wrap_sum", 32'(rsp_sum), 32'h0);
`ifdef ADDR_ARB_OVF_EN
        check("wrap_ovf", 32'(rsp_ovf), 32'h1);
`endif
        ra[0] = 14'h1000;
        rb[0] = 14'h0FFF;
        step();
        check("nowrap_sum", 32'(rsp_sum), 32'h1FFF);
`ifdef ADDR_ARB_OVF_EN
        check("nowrap_ovf", 32'(rsp_ovf), 32'h0);
`endif

        // Asynchronous reset while a response is held
        rsp_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        req = 3'b110;
        check("arst_valid", 32'(rsp_valid), 32'h0);
        check("arst_sum", 32'(rsp_sum), 32'h0);
        check("arst_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("arst_first", 32'(last_g), 32'h1);
        rsp_ready = 1'b1;
        req       = 3'b000;

        // Randomized traffic; idle requesters drive X operands
        for (int n = 0; n < 400; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1)) begin
                    req[i] = 1'b1;
                    ra[i]  = AW'($urandom);
                    rb[i]  = AW'($urandom);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    ra[i] = 'x;
                    rb[i] = 'x;
                end
            end
            step();
            if (last_g >= 0) req[last_g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_adder_arb.md
Name: addr_adder_arb

Overview:
- Round-robin arbiter and sequencer that shares one 14-bit word-address carry-lookahead adder (operand bits [15:2]) among NREQ requesters, e.g. fetch PC+4, branch target and load/store address generation.
- Selects one requester per cycle and steers its operands to the external adder.
- Captures sum and carry-out into a one-entry response register with valid/ready backpressure.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 14, operand/sum width (address bits [15:2]).
- IDW, 2, width of requester index; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held until granted.
- req_a  in  NREQ*AW  packed operand A, requester i at [i*AW +: AW].
- req_b  in  NREQ*AW  packed operand B, same packing.
- gnt  out  NREQ  one-hot grant; combinational, same cycle as accept.
- add_a  out  AW  operand A to shared adder.
- add_b  out  AW  operand B to shared adder.
- add_s  in  AW  sum from shared adder (combinational).
- add_cout  in  1  carry-out from shared adder.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_id  out  IDW  index of the requester that produced the response.
- rsp_sum  out  AW  registered sum.

Behaviour:
- The clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_id=0, round-robin pointer ptr=0, state=EMPTY. gnt=0 while rst_n=0.
- State machine on the response register:
  - EMPTY: accept allowed.
  - FULL: accept allowed only when rsp_ready=1.
  - accept_ok = (state==EMPTY) | rsp_ready.
- Arbitration (combinational):
  - If accept_ok and any req is set, grant the first set req found searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - gnt is one-hot or zero; never more than one bit set.
- Operand steering:
  - add_a/add_b = granted requester's req_a/req_b.
  - With no grant, add_a = add_b = 0, so the adder does not toggle.
- On the clk edge with a grant:
  - rsp_sum <= add_s, rsp_id <= granted index, state <= FULL.
  - ptr <= (granted index + 1) mod NREQ.
  - Latency: grant cycle N gives rsp_valid=1 in cycle N+1.
- FULL with rsp_ready=1 and no grant: state <= EMPTY, rsp_valid falls next cycle.
- FULL with rsp_ready=1 and a grant in the same cycle: the register reloads and state stays FULL. Sustained throughput is one result per cycle.
- FULL with rsp_ready=0: gnt=0; rsp_sum/rsp_id/rsp_valid held stable; ptr unchanged.
- ptr changes only on a grant. A requester is served at most once per NREQ grants while others are waiting (no starvation).
- Requester protocol: a requester seeing gnt[i]=1 at a clock edge considers its request consumed. It may drop req[i] or present a new operand pair next cycle.
- Arithmetic: rsp_sum = (a+b) mod 2^AW, with no carry-in. add_cout is ignored unless the optional feature is compiled in.
- req bits at or above NREQ do not exist. X on req_a/req_b of non-granted requesters must not propagate to add_a/add_b.
- Reset mid-operation: an in-flight response is discarded immediately (asynchronous), ptr returns to 0, and no grant is issued until rst_n=1.

Optional Feature:
- Macro: ADDR_ARB_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), reset value 0.
  - rsp_ovf is loaded from add_cout with rsp_sum and held under backpressure identically.
  - rsp_ovf=1 flags address wrap past 0xFFFC.
- Not defined:
  - Port absent; add_cout unused; no ovf register.

Test Plan:
- Reset: rst_n=0 with req=3'b111 -> gnt=0, rsp_valid=0, rsp_sum=0, rsp_id=0. After release, first grant goes to requester 0.
- Single request: req=3'b001, a=0x0001, b=0x0001, rsp_ready=1 -> gnt=3'b001 same cycle; next cycle rsp_valid=1, rsp_sum=0x0002, rsp_id=0; one cycle later rsp_valid=0.
- Round-robin: req=3'b111 held 6 cycles, rsp_ready=1, requester i operands a=i, b=0x0100 -> grants 0,1,2,0,1,2 on consecutive cycles; rsp_sum sequence 0x0100, 0x0101, 0x0102, ... with rsp_valid continuously 1.
- Backpressure: response FULL (sum 0x0010, id 1), rsp_ready=0 for 3 cycles with req=3'b101 -> gnt=0 throughout, rsp_sum/rsp_id stable. rsp_ready=1 -> grant to 2 that cycle, next rsp_id=2.
- Wrap: a=0x3FFF, b=0x0001 -> rsp_sum=0x0000; with ADDR_ARB_OVF_EN defined rsp_ovf=1; a=0x1000, b=0x0FFF -> rsp_sum=0x1FFF, rsp_ovf=0.
- Reset mid-operation: rst_n pulsed low while FULL with rsp_ready=0 -> rsp_valid drops without waiting for a clock edge. After release with req=3'b110, first grant goes to requester 1 (ptr=0, so the search starts at 0).
